// File: rtl/mem_fetch_sequencer_pkg.sv
// Shared types for the memory fetch sequencer: controller states and dual-rail phase codes.
package mem_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_DATA = 3'd1,
    I_NULL = 3'd2,
    C_DATA = 3'd3,
    C_NULL = 3'd4,
    RESP   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_T    = 2'b10;
  localparam logic [1:0] DR_F    = 2'b01;

  // States that wait on a completion input and are therefore covered by the timeout.
  function automatic logic is_wait_state(state_e s);
    return (s == I_DATA) || (s == I_NULL) || (s == C_DATA) || (s == C_NULL);
  endfunction

endpackage

// File: rtl/mem_fetch_sequencer_if.sv
// Bundle of core-side fetch handshake, memory/demux control and completion signals.
interface mem_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              need_const;
  logic              data_done;
  logic              null_done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              ph0_t;
  logic              ph0_f;
  logic              ir_load;
  logic              const_load;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_const;
  logic              err;
  logic              err_clr;

  modport master (
    output req_valid, pc_load, pc_load_val, need_const, data_done, null_done,
           resp_ready, err_clr,
    input  req_ready, mem_rd, mem_addr, ph0_t, ph0_f, ir_load, const_load,
           resp_valid, resp_const, err
  );

  modport slave (
    input  req_valid, pc_load, pc_load_val, need_const, data_done, null_done,
           resp_ready, err_clr,
    output req_ready, mem_rd, mem_addr, ph0_t, ph0_f, ir_load, const_load,
           resp_valid, resp_const, err
  );
endinterface

// File: rtl/mem_fetch_sequencer_ncl_sync.sv
// N-flop synchronizer bringing an asynchronous NCL completion level into the clock domain.
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[N-2:0], async_i};
    end
  end

  assign sync_o = chain_q[N-1];

endmodule

// File: rtl/mem_fetch_sequencer.sv
// Fetch controller: sequences opcode and optional constant reads into the dual-rail demux,
// inserting a NULL wavefront after every DATA wavefront and timing out stalled completions.
module mem_fetch_sequencer
  import mem_fetch_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                SYNC_STAGES = 2,
  parameter int                TIMEOUT_CYC = 64
) (
  input logic       clk,
  input logic       rst_n,
  mem_fetch_if.slave bus
);

  localparam int              CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              need_q, need_d;
  logic              ir_load_q, ir_load_d;
  logic              const_load_q, const_load_d;
  logic              data_done_s, null_done_s;
  logic              timeout;
  logic [1:0]        ph0;

  ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(bus.data_done),
    .sync_o (data_done_s)
  );

  ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_null (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(bus.null_done),
    .sync_o (null_done_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      need_q       <= 1'b0;
      ir_load_q    <= 1'b0;
      const_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      need_q       <= need_d;
      ir_load_q    <= ir_load_d;
      const_load_q <= const_load_d;
    end
  end

  assign timeout = (TIMEOUT_CYC != 0) && is_wait_state(state_q) && (cnt_q == CNT_MAX);

  // need_const is valid while ir_load is high, so I_NULL may already use it that same cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q + 1'b1;
    need_d       = ir_load_q ? bus.need_const : need_q;
    ir_load_d    = 1'b0;
    const_load_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pc_load) begin
          pc_d = bus.pc_load_val;
        end else if (bus.req_valid) begin
          state_d = I_DATA;
          cnt_d   = '0;
        end
      end
      I_DATA: begin
        if (data_done_s) begin
          ir_load_d = 1'b1;
          state_d   = I_NULL;
          cnt_d     = '0;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      I_NULL: begin
        if (null_done_s) begin
          pc_d    = pc_q + 1'b1;
          state_d = need_d ? C_DATA : RESP;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      C_DATA: begin
        if (data_done_s) begin
          const_load_d = 1'b1;
          state_d      = C_NULL;
          cnt_d        = '0;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      C_NULL: begin
        if (null_done_s) begin
          pc_d    = pc_q + 1'b1;
          state_d = RESP;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      ERR: begin
        if (bus.err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ph0 = DR_NULL;
    if (state_q == I_DATA) ph0 = DR_T;
    else if (state_q == C_DATA) ph0 = DR_F;
  end

  assign bus.ph0_t      = ph0[1];
  assign bus.ph0_f      = ph0[0];
  assign bus.mem_rd     = (state_q == I_DATA) || (state_q == C_DATA);
  assign bus.mem_addr   = bus.mem_rd ? pc_q : '0;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_const = (state_q == RESP) && need_q;
  assign bus.err        = (state_q == ERR);
  assign bus.ir_load    = ir_load_q;
  assign bus.const_load = const_load_q;

endmodule
